regfile_wb_sched: RTL and testbench

- Scoreboard and writeback scheduler for the 32x64 register file, which has one write port and two combinational read ports.
- Gates instruction issue on RAW and WAW hazards against in-flight destination registers.
- Arbitrates two writeback sources, ALU and memory/load unit, onto the single write port with round-robin fairness.
- Drives the register file's write_sig, write_reg and write_val directly from a registered output stage.

---
 rtl/regfile_wb_sched_if.sv | 44 ++++
 rtl/regfile_wb_sched.sv | 76 +++++++
 tb/tb_regfile_wb_sched.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_sched_if.sv
// regfile_wb_sched_if: issue/writeback/register-file-write bundle for the writeback scheduler
// Signals: issue_* (decode handshake), alu_wb_* / mem_wb_* (writeback requests),
// write_* (register-file write port), busy_mask, wb_err, idle (status).
// master = driving side (decode, execution units, observer), slave = scheduler.
interface regfile_wb_sched_if #(
    parameter int XLEN = 64,
    parameter int NREGS = 32,
    parameter int AW = 5
);
    logic            issue_valid;
    logic [AW-1:0]   issue_rs1;
    logic [AW-1:0]   issue_rs2;
    logic [AW-1:0]   issue_rd;
    logic            issue_wr;
    logic            issue_ready;
    logic            alu_wb_valid;
    logic [AW-1:0]   alu_wb_rd;
    logic [XLEN-1:0] alu_wb_val;
    logic            alu_wb_ready;
    logic            mem_wb_valid;
    logic [AW-1:0]   mem_wb_rd;
    logic [XLEN-1:0] mem_wb_val;
    logic            mem_wb_ready;
    logic            write_sig;
    logic [AW-1:0]   write_reg;
    logic [XLEN-1:0] write_val;
    logic [NREGS-1:0] busy_mask;
    logic            wb_err;
    logic            idle;
    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr,
        output alu_wb_valid, alu_wb_rd, alu_wb_val,
        output mem_wb_valid, mem_wb_rd, mem_wb_val,
        input  issue_ready, alu_wb_ready, mem_wb_ready,
        input  write_sig, write_reg, write_val, busy_mask, wb_err, idle
    );
    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr,
        input  alu_wb_valid, alu_wb_rd, alu_wb_val,
        input  mem_wb_valid, mem_wb_rd, mem_wb_val,
        output issue_ready, alu_wb_ready, mem_wb_ready,
        output write_sig, write_reg, write_val, busy_mask, wb_err, idle
    );
endinterface

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: scoreboard and round-robin writeback scheduler for a 1W2R register file
// Ports: clk; reset (asynchronous, active-high); bus (slave modport) carrying the issue
// handshake, ALU and MEM writeback requests, the registered register-file write port
// (write_sig/write_reg/write_val), busy_mask, sticky wb_err and idle.
module regfile_wb_sched #(
    parameter int XLEN = 64,
    parameter int NREGS = 32,
    parameter int AW = 5
) (
    input logic clk,
    input logic reset,
    regfile_wb_sched_if.slave bus
);
    logic [NREGS-1:0] r_busy;
    logic             r_write_sig;
    logic [AW-1:0]    r_write_reg;
    logic [XLEN-1:0]  r_write_val;
    logic             r_wb_err;
    logic             r_last_mem;
    logic             w_ready;
    logic             w_fire;
    logic             w_alu_g;
    logic             w_mem_g;
    logic             w_grant;
    logic [AW-1:0]    w_rd;
    logic [XLEN-1:0]  w_val;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_busy_nxt;

    always_comb begin
        w_ready = !r_busy[bus.issue_rs1] && !r_busy[bus.issue_rs2] && !(bus.issue_wr && r_busy[bus.issue_rd]);
        w_fire = bus.issue_valid && w_ready;
        // On a tie the source that did not win last time gets the port.
        w_alu_g = bus.alu_wb_valid && (!bus.mem_wb_valid || r_last_mem);
        w_mem_g = bus.mem_wb_valid && (!bus.alu_wb_valid || !r_last_mem);
        w_grant = w_alu_g || w_mem_g;
        w_rd = w_mem_g ? bus.mem_wb_rd : bus.alu_wb_rd;
        w_val = w_mem_g ? bus.mem_wb_val : bus.alu_wb_val;
        w_set = (w_fire && bus.issue_wr) ? (NREGS'(1) << bus.issue_rd) : '0;
        // The busy bit drops in the same edge the register file commits the write.
        w_clr = r_write_sig ? (NREGS'(1) << r_write_reg) : '0;
        w_busy_nxt = ((r_busy & ~w_clr) | w_set) & ~NREGS'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy      <= '0;
            r_write_sig <= 1'b0;
            r_write_reg <= '0;
            r_write_val <= '0;
            r_wb_err    <= 1'b0;
            r_last_mem  <= 1'b0;
        end else begin
            r_busy      <= w_busy_nxt;
            r_write_sig <= w_grant && (w_rd != '0);
            if (w_grant) begin
                r_write_reg <= w_rd;
                r_write_val <= w_val;
                r_last_mem  <= w_mem_g;
            end
            if (w_grant && (w_rd != '0) && !r_busy[w_rd])
                r_wb_err <= 1'b1;
        end
    end

    assign bus.issue_ready  = w_ready;
    assign bus.alu_wb_ready = w_alu_g;
    assign bus.mem_wb_ready = w_mem_g;
    assign bus.write_sig    = r_write_sig;
    assign bus.write_reg    = r_write_reg;
    assign bus.write_val    = r_write_val;
    assign bus.busy_mask    = r_busy;
    assign bus.wb_err       = r_wb_err;
    assign bus.idle         = (r_busy == '0) && !r_write_sig;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: self-checking bench for regfile_wb_sched with a write-port scoreboard
module tb_regfile_wb_sched;
    localparam int XLEN = 64;
    localparam int NREGS = 32;
    localparam int AW = 5;
    typedef logic [XLEN+AW:0] wb_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int pass_cnt = 0;
    int total_cnt = 0;
    wb_t q[$];
    wb_t exp_wb;
    wb_t got_wb;

    regfile_wb_sched_if #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) bus ();
    regfile_wb_sched #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    assign got_wb = {bus.write_sig, bus.write_reg, bus.write_val};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.issue_valid = 1'b0;
        bus.issue_rs1 = '0;
        bus.issue_rs2 = '0;
        bus.issue_rd = '0;
        bus.issue_wr = 1'b0;
        bus.alu_wb_valid = 1'b0;
        bus.alu_wb_rd = '0;
        bus.alu_wb_val = '0;
        bus.mem_wb_valid = 1'b0;
        bus.mem_wb_rd = '0;
        bus.mem_wb_val = '0;
    endtask

    task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic [AW-1:0] rd, input logic wr);
        bus.issue_valid = 1'b1;
        bus.issue_rs1 = rs1;
        bus.issue_rs2 = rs2;
        bus.issue_rd = rd;
        bus.issue_wr = wr;
        step();
        bus.issue_valid = 1'b0;
    endtask

    task automatic push_wb(input logic [AW-1:0] rd, input logic [XLEN-1:0] val);
        q.push_back({rd != '0, rd, val});
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #12 reset = 1'b0;
        step();
        total_cnt++; if (bus.idle !== 1'b1) $display("FAIL reset_idle got %b expected 1", bus.idle); else pass_cnt++;
        total_cnt++; if (got_wb !== '0) $display("FAIL reset_write got %h expected 0", got_wb); else pass_cnt++;
        total_cnt++; if ({bus.busy_mask, bus.wb_err} !== '0) $display("FAIL reset_busy_err got %h/%b expected 0/0", bus.busy_mask, bus.wb_err); else pass_cnt++;
        issue(0, 0, 4, 1'b1);
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_rd = 20;
        bus.alu_wb_val = 64'hDEAD;
        step();
        bus.alu_wb_valid = 1'b0;
        total_cnt++; if ({bus.busy_mask, bus.wb_err, bus.write_sig} !== {32'h10, 1'b1, 1'b1}) $display("FAIL pre_reset_state got %h/%b/%b expected 10/1/1", bus.busy_mask, bus.wb_err, bus.write_sig); else pass_cnt++;
        #3 reset = 1'b1;
        #1;
        total_cnt++; if ({bus.busy_mask, bus.write_sig, bus.wb_err, bus.idle} !== {32'h0, 1'b0, 1'b0, 1'b1}) $display("FAIL async_reset got busy=%h sig=%b err=%b idle=%b expected 0/0/0/1", bus.busy_mask, bus.write_sig, bus.wb_err, bus.idle); else pass_cnt++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_raw();
        issue(0, 0, 5, 1'b1);
        bus.issue_rs1 = 5;
        bus.issue_rd = 0;
        bus.issue_wr = 1'b0;
        #1;
        total_cnt++; if (bus.issue_ready !== 1'b0) $display("FAIL raw_stall got %b expected 0", bus.issue_ready); else pass_cnt++;
        total_cnt++; if (bus.busy_mask !== 32'h20) $display("FAIL raw_busy got %h expected 20", bus.busy_mask); else pass_cnt++;
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_rd = 5;
        bus.alu_wb_val = 64'h1234;
        #1;
        total_cnt++; if ({bus.alu_wb_ready, bus.mem_wb_ready} !== 2'b10) $display("FAIL raw_grant got %b expected 10", {bus.alu_wb_ready, bus.mem_wb_ready}); else pass_cnt++;
        push_wb(5, 64'h1234);
        step();
        bus.alu_wb_valid = 1'b0;
        exp_wb = q.pop_front();
        total_cnt++; if (got_wb !== exp_wb) $display("FAIL raw_write got %h expected %h", got_wb, exp_wb); else pass_cnt++;
        total_cnt++; if (bus.issue_ready !== 1'b0) $display("FAIL raw_commit_cycle got %b expected 0", bus.issue_ready); else pass_cnt++;
        step();
        total_cnt++; if ({bus.issue_ready, bus.busy_mask, bus.wb_err} !== {1'b1, 32'h0, 1'b0}) $display("FAIL raw_release got rdy=%b busy=%h err=%b expected 1/0/0", bus.issue_ready, bus.busy_mask, bus.wb_err); else pass_cnt++;
        bus.issue_rs1 = 0;
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] alu_rd_t [4] = '{5'd3, 5'd3, 5'd10, 5'd10};
        logic [AW-1:0] mem_rd_t [4] = '{5'd7, 5'd8, 5'd8, 5'd0};
        logic          mem_v_t  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic          win_mem  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        issue(0, 0, 3, 1'b1);
        issue(0, 0, 7, 1'b1);
        issue(0, 0, 8, 1'b1);
        issue(0, 0, 10, 1'b1);
        total_cnt++; if (bus.busy_mask !== 32'h588) $display("FAIL rr_busy got %h expected 588", bus.busy_mask); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            bus.alu_wb_valid = 1'b1;
            bus.alu_wb_rd = alu_rd_t[k];
            bus.alu_wb_val = 64'hA000 + 64'(alu_rd_t[k]);
            bus.mem_wb_valid = mem_v_t[k];
            bus.mem_wb_rd = mem_rd_t[k];
            bus.mem_wb_val = 64'hB000 + 64'(mem_rd_t[k]);
            #1;
            total_cnt++; if ({bus.alu_wb_ready, bus.mem_wb_ready} !== {!win_mem[k], win_mem[k]}) $display("FAIL rr_grant%0d got %b expected %b", k, {bus.alu_wb_ready, bus.mem_wb_ready}, {!win_mem[k], win_mem[k]}); else pass_cnt++;
            if (win_mem[k]) push_wb(mem_rd_t[k], 64'hB000 + 64'(mem_rd_t[k]));
            else push_wb(alu_rd_t[k], 64'hA000 + 64'(alu_rd_t[k]));
            step();
            exp_wb = q.pop_front();
            total_cnt++; if (got_wb !== exp_wb) $display("FAIL rr_write%0d got %h expected %h", k, got_wb, exp_wb); else pass_cnt++;
        end
        idle_inputs();
        step();
        total_cnt++; if ({bus.busy_mask, bus.wb_err, bus.idle} !== {32'h0, 1'b0, 1'b1}) $display("FAIL rr_drain got busy=%h err=%b idle=%b expected 0/0/1", bus.busy_mask, bus.wb_err, bus.idle); else pass_cnt++;
    endtask

    task automatic test_waw();
        issue(0, 0, 9, 1'b1);
        bus.issue_rd = 9;
        bus.issue_wr = 1'b1;
        #1;
        total_cnt++; if (bus.issue_ready !== 1'b0) $display("FAIL waw_stall got %b expected 0", bus.issue_ready); else pass_cnt++;
        bus.issue_wr = 1'b0;
        #1;
        total_cnt++; if (bus.issue_ready !== 1'b1) $display("FAIL waw_nowrite got %b expected 1", bus.issue_ready); else pass_cnt++;
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_rd = 9;
        bus.alu_wb_val = 64'h9999_0000_1111;
        push_wb(9, 64'h9999_0000_1111);
        step();
        idle_inputs();
        exp_wb = q.pop_front();
        total_cnt++; if (got_wb !== exp_wb) $display("FAIL waw_write got %h expected %h", got_wb, exp_wb); else pass_cnt++;
        step();
        total_cnt++; if (bus.busy_mask !== 32'h0) $display("FAIL waw_release got %h expected 0", bus.busy_mask); else pass_cnt++;
    endtask

    task automatic test_zero();
        issue(0, 0, 0, 1'b1);
        total_cnt++; if (bus.busy_mask !== 32'h0) $display("FAIL zero_issue_busy got %h expected 0", bus.busy_mask); else pass_cnt++;
        bus.mem_wb_valid = 1'b1;
        bus.mem_wb_rd = 0;
        bus.mem_wb_val = 64'hFFFF;
        #1;
        total_cnt++; if ({bus.alu_wb_ready, bus.mem_wb_ready} !== 2'b01) $display("FAIL zero_grant got %b expected 01", {bus.alu_wb_ready, bus.mem_wb_ready}); else pass_cnt++;
        push_wb(0, 64'hFFFF);
        step();
        idle_inputs();
        exp_wb = q.pop_front();
        total_cnt++; if (got_wb !== exp_wb) $display("FAIL zero_write got %h expected %h", got_wb, exp_wb); else pass_cnt++;
        total_cnt++; if ({bus.wb_err, bus.idle, bus.busy_mask} !== {1'b0, 1'b1, 32'h0}) $display("FAIL zero_status got err=%b idle=%b busy=%h expected 0/1/0", bus.wb_err, bus.idle, bus.busy_mask); else pass_cnt++;
    endtask

    task automatic test_spurious();
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_rd = 12;
        bus.alu_wb_val = 64'h55;
        push_wb(12, 64'h55);
        step();
        idle_inputs();
        exp_wb = q.pop_front();
        total_cnt++; if (got_wb !== exp_wb) $display("FAIL spur_write got %h expected %h", got_wb, exp_wb); else pass_cnt++;
        total_cnt++; if (bus.wb_err !== 1'b1) $display("FAIL spur_err got %b expected 1", bus.wb_err); else pass_cnt++;
        step();
        step();
        total_cnt++; if ({bus.wb_err, bus.busy_mask, bus.write_sig} !== {1'b1, 32'h0, 1'b0}) $display("FAIL spur_sticky got err=%b busy=%h sig=%b expected 1/0/0", bus.wb_err, bus.busy_mask, bus.write_sig); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_raw();
        test_back_to_back();
        test_waw();
        test_zero();
        test_spurious();
        total_cnt++; if (q.size() != 0) $display("FAIL scoreboard_leftover got %0d expected 0", q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
